// File: rtl/bundle_fetch_queue.sv
// Instruction-bundle fetch stage: generates the fetch PC, buffers one bundle per cycle in a
// DEPTH-entry queue and presents the head bundle to the issue lanes; redirect flushes and squashes.
module bundle_fetch_queue #(
   parameter int                NUM_LANES = 4,
   parameter int                INST_W    = 32,
   parameter int                PC_W      = 32,
   parameter int                DEPTH     = 4,
   parameter logic [PC_W-1:0]   RESET_PC  = '0,
   parameter logic [INST_W-1:0] NOP_INST  = INST_W'(32'h00000013),
   localparam int               CW        = $clog2(DEPTH+1),
   localparam int               PW        = $clog2(DEPTH),
   localparam int               BW        = NUM_LANES*INST_W
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] fetch_pc,
   input  logic [BW-1:0]   mem_bundle,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            issue_valid,
   input  logic            issue_ready,
   output logic [BW-1:0]   issue_bundle,
   output logic [PC_W-1:0] issue_pc,
   output logic            squash,
   output logic [CW-1:0]   count
);
   localparam int BSTEP = BW/8;

   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            squash_q, squash_d;
   logic [PC_W-1:0] ent_pc_q [DEPTH];
   logic [PC_W-1:0] ent_pc_d [DEPTH];
   logic [BW-1:0]   ent_bd_q [DEPTH];
   logic [BW-1:0]   ent_bd_d [DEPTH];
   logic            pop, push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign issue_valid  = (count_q != '0);
   assign issue_bundle = issue_valid ? ent_bd_q[rd_ptr_q] : {NUM_LANES{NOP_INST}};
   assign issue_pc     = issue_valid ? ent_pc_q[rd_ptr_q] : '0;
   assign fetch_pc     = fetch_pc_q;
   assign squash       = squash_q;
   assign count        = count_q;

   // A pop frees a slot in the same cycle, so a full queue keeps streaming.
   assign pop  = issue_valid & issue_ready;
   assign push = ~redirect & ((count_q < CW'(DEPTH)) | pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      squash_d   = redirect;
      ent_pc_d   = ent_pc_q;
      ent_bd_d   = ent_bd_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            ent_pc_d[wr_ptr_q] = fetch_pc_q;
            ent_bd_d[wr_ptr_q] = mem_bundle;
            wr_ptr_d           = ptr_inc(wr_ptr_q);
            fetch_pc_d         = fetch_pc_q + PC_W'(BSTEP);
         end
         if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         squash_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_pc_q[i] <= '0;
            ent_bd_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         squash_q   <= squash_d;
         ent_pc_q   <= ent_pc_d;
         ent_bd_q   <= ent_bd_d;
      end
   end
endmodule

// File: tb/tb_bundle_fetch_queue.sv
// Bench for bundle_fetch_queue: a default build (A) and a DEPTH=3, NUM_LANES=2 build (B),
// both checked every cycle against queue-based reference models.
module tb_bundle_fetch_queue;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0, bad = 0;
   bit done = 1'b0;

   // build A: defaults
   logic [31:0]  fpa, rpa, ipa;
   logic [127:0] mba, iba;
   logic         rda, rya, iva, sqa;
   logic [2:0]   cnta;
   // build B: DEPTH=3, NUM_LANES=2
   logic [31:0]  fpb, rpb, ipb;
   logic [63:0]  mbb, ibb;
   logic         rdb, ryb, ivb, sqb;
   logic [1:0]   cntb;

   function automatic logic [127:0] mem_a(input logic [31:0] pc);
      logic [127:0] b;
      for (int i = 0; i < 4; i++) b[i*32 +: 32] = (pc >> 4) + (32'(i) << 24);
      return b;
   endfunction
   function automatic logic [63:0] mem_b(input logic [31:0] pc);
      logic [63:0] b;
      for (int i = 0; i < 2; i++) b[i*32 +: 32] = (pc >> 3) + (32'(i) << 24);
      return b;
   endfunction

   assign mba = mem_a(fpa);
   assign mbb = mem_b(fpb);

   bundle_fetch_queue dut_a (
      .clk(clk), .rst(rst), .fetch_pc(fpa), .mem_bundle(mba), .redirect(rda), .redirect_pc(rpa),
      .issue_valid(iva), .issue_ready(rya), .issue_bundle(iba), .issue_pc(ipa), .squash(sqa), .count(cnta));

   bundle_fetch_queue #(.NUM_LANES(2), .DEPTH(3)) dut_b (
      .clk(clk), .rst(rst), .fetch_pc(fpb), .mem_bundle(mbb), .redirect(rdb), .redirect_pc(rpb),
      .issue_valid(ivb), .issue_ready(ryb), .issue_bundle(ibb), .issue_pc(ipb), .squash(sqb), .count(cntb));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference models: a queue of (pc, bundle) plus the next fetch address
   logic [31:0]  qa_pc[$], qb_pc[$];
   logic [127:0] qa_bd[$];
   logic [63:0]  qb_bd[$];
   logic [31:0]  mfa = 0, mfb = 0;
   bit           msa = 0, msb = 0;
   int           nb_push = 0;

   always @(posedge clk or posedge rst) begin
      bit pop, push;
      if (rst) begin
         qa_pc.delete(); qa_bd.delete(); qb_pc.delete(); qb_bd.delete();
         mfa = 0; mfb = 0; msa = 0; msb = 0;
      end else begin
         pop  = qa_pc.size() != 0 && rya;
         push = !rda && (qa_pc.size() < 4 || pop);
         if (pop) begin void'(qa_pc.pop_front()); void'(qa_bd.pop_front()); end
         msa = rda;
         if (rda) begin
            qa_pc.delete(); qa_bd.delete(); mfa = rpa;
         end else if (push) begin
            qa_pc.push_back(mfa); qa_bd.push_back(mem_a(mfa)); mfa += 16;
         end
         pop  = qb_pc.size() != 0 && ryb;
         push = !rdb && (qb_pc.size() < 3 || pop);
         if (pop) begin void'(qb_pc.pop_front()); void'(qb_bd.pop_front()); end
         msb = rdb;
         if (rdb) begin
            qb_pc.delete(); qb_bd.delete(); mfb = rpb;
         end else if (push) begin
            qb_pc.push_back(mfb); qb_bd.push_back(mem_b(mfb)); mfb += 8; nb_push++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && !done) begin
         chk("a_fetch_pc", 128'(fpa), 128'(mfa));
         chk("a_count", 128'(cnta), 128'(qa_pc.size()));
         chk("a_valid", 128'(iva), 128'(qa_pc.size() != 0));
         chk("a_issue_pc", 128'(ipa), 128'(qa_pc.size() != 0 ? qa_pc[0] : 32'h0));
         chk("a_bundle", iba, qa_pc.size() != 0 ? qa_bd[0] : {4{32'h13}});
         chk("a_squash", 128'(sqa), 128'(msa));
         chk("b_fetch_pc", 128'(fpb), 128'(mfb));
         chk("b_count", 128'(cntb), 128'(qb_pc.size()));
         chk("b_count_le3", 128'(cntb <= 2'd3), 128'(1));
         chk("b_issue_pc", 128'(ipb), 128'(qb_pc.size() != 0 ? qb_pc[0] : 32'h0));
         chk("b_bundle", 128'(ibb), 128'(qb_pc.size() != 0 ? qb_bd[0] : {2{32'h13}}));
         chk("b_squash", 128'(sqb), 128'(msb));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   // build B: random ready with occasional redirects for the whole run
   initial begin
      rdb = 0; ryb = 0; rpb = 0;
      while (!done) begin
         step();
         ryb = $urandom_range(0, 3) != 0;
         rdb = $urandom_range(0, 31) == 0;
         rpb = $urandom & ~32'h7;
      end
   end

   initial begin
      rda = 0; rya = 0; rpa = 0;
      step(2);
      chk("rst_fetch_pc", 128'(fpa), 128'h0);
      chk("rst_count", 128'(cnta), 128'h0);
      chk("rst_valid", 128'(iva), 128'h0);
      chk("rst_bundle", iba, {4{32'h13}});
      chk("rst_issue_pc", 128'(ipa), 128'h0);
      chk("rst_squash", 128'(sqa), 128'h0);
      rst = 0;
      // stall from reset: queue fills to 4, fetch stops at 64
      step(10);
      chk("stall_count", 128'(cnta), 128'd4);
      chk("stall_fetch", 128'(fpa), 128'd64);
      chk("stall_head", 128'(ipa), 128'd0);
      rya = 1;
      step();
      chk("full_stream_head", 128'(ipa), 128'd16);
      chk("full_stream_cnt", 128'(cnta), 128'd4);
      chk("full_stream_fetch", 128'(fpa), 128'd80);
      step();
      chk("full_stream_head2", 128'(ipa), 128'd32);
      // build count=3, then redirect while popping
      rya = 0; rda = 1; rpa = 32'h100;
      step();
      rda = 0;
      step(3);
      chk("three_count", 128'(cnta), 128'd3);
      rya = 1; rda = 1; rpa = 32'h200;
      step();
      rda = 0;
      chk("redir_count", 128'(cnta), 128'd0);
      chk("redir_valid", 128'(iva), 128'd0);
      chk("redir_squash", 128'(sqa), 128'd1);
      chk("redir_fetch", 128'(fpa), 128'h200);
      step();
      chk("redir_head", 128'(ipa), 128'h200);
      chk("redir_sq_drop", 128'(sqa), 128'd0);
      step();
      chk("one_per_cycle", 128'(ipa), 128'h210);
      chk("one_per_cycle_bd", iba, mem_a(32'h210));
      // pc wrap
      rya = 0; rda = 1; rpa = 32'hFFFF_FFF0;
      step();
      rda = 0;
      step();
      chk("wrap_fetch", 128'(fpa), 128'h0);
      chk("wrap_head", 128'(ipa), 128'hFFFF_FFF0);
      // back-to-back redirects: last wins
      rda = 1; rpa = 32'h300;
      step();
      rpa = 32'h400;
      step();
      chk("b2b_squash", 128'(sqa), 128'd1);
      chk("b2b_fetch", 128'(fpa), 128'h400);
      rda = 0; rya = 1;
      step();
      chk("b2b_head", 128'(ipa), 128'h400);
      // asynchronous reset mid-stream
      step(3);
      #3 rst = 1;
      #1;
      chk("arst_count", 128'(cnta), 128'd0);
      chk("arst_valid", 128'(iva), 128'd0);
      chk("arst_fetch", 128'(fpa), 128'd0);
      chk("arst_bundle", iba, {4{32'h13}});
      step();
      rst = 0;
      // random phase
      for (int i = 0; i < 400; i++) begin
         step();
         rya = $urandom_range(0, 3) != 0;
         rda = $urandom_range(0, 15) == 0;
         rpa = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : ($urandom & ~32'hF);
      end
      step();
      chk("b_ptr_wraps", 128'(nb_push >= 15), 128'd1);
      done = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
